// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//   Constants and types shared by the MIPS pipeline: the fetch stage, the
//   ID-stage control and the 32-bit 4-way next-PC mux all use the pc_src
//   encoding defined here.
//
//   Contents:
//     PC_SRC_*   2-bit next-PC select codes
//     NOP_INSTR  bubble instruction (sll $0,$0,0)
//     RESET_PC   default PC loaded on reset
//     if_id_t    IF/ID pipeline latch payload
//     word_align forces an address onto a 4-byte boundary
// ----------------------------------------------------------------------------
package mips_pkg;

   localparam logic [1:0] PC_SRC_SEQ = 2'b00;  // PC + 4
   localparam logic [1:0] PC_SRC_BR  = 2'b01;  // taken branch
   localparam logic [1:0] PC_SRC_J   = 2'b10;  // j / jal
   localparam logic [1:0] PC_SRC_JR  = 2'b11;  // jr / jalr

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        valid;
   } if_id_t;

   // Instruction addresses are always word aligned; the low two bits of any
   // incoming target are simply discarded.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory bus between the fetch stage and instruction memory.
//
//   Signals:
//     imem_addr   fetch -> mem  word address of the instruction wanted
//     imem_rdata  mem -> fetch  instruction word for imem_addr
//     imem_ready  mem -> fetch  imem_rdata is valid this cycle
//
//   Modports:
//     master  fetch-stage side
//     slave   instruction-memory side
// ----------------------------------------------------------------------------
interface fetch_stage_if;

   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );

endinterface

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline latch. Each edge it either holds, loads a bubble, or loads
//   a freshly fetched instruction. Priority: reset > hold > bubble > load.
//   With no control asserted it keeps its contents.
//
//   Ports:
//     clk          rising-edge clock
//     reset        synchronous, active-high; loads a bubble
//     hold_i       keep current contents (pipeline stall)
//     bubble_i     load NOP_INSTR / pc_plus4 0 / valid 0
//     load_i       load instr_i and pc_plus4_i as a valid instruction
//     instr_i      fetched instruction word
//     pc_plus4_i   PC+4 of the fetched instruction
//     instr_o      latched instruction to ID
//     pc_plus4_o   latched PC+4 to ID
//     valid_o      1 = real instruction, 0 = bubble
// ----------------------------------------------------------------------------
module if_id_reg #(
   parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hold_i,
   input  logic        bubble_i,
   input  logic        load_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_plus4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_plus4_o,
   output logic        valid_o
);

   mips_pkg::if_id_t latch_q, latch_d;
   mips_pkg::if_id_t bubble;

   always_comb begin
      bubble.instr    = NOP_INSTR;
      bubble.pc_plus4 = 32'd0;
      bubble.valid    = 1'b0;
   end

   always_comb begin
      latch_d = latch_q;
      if (hold_i) begin
         latch_d = latch_q;
      end else if (bubble_i) begin
         latch_d = bubble;
      end else if (load_i) begin
         latch_d.instr    = instr_i;
         latch_d.pc_plus4 = pc_plus4_i;
         latch_d.valid    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         latch_q <= bubble;
      end else begin
         latch_q <= latch_d;
      end
   end

   assign instr_o    = latch_q.instr;
   assign pc_plus4_o = latch_q.pc_plus4;
   assign valid_o    = latch_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC,
//   computes PC+4, selects the next PC, drives the instruction-memory address
//   and feeds the IF/ID latch.
//
//   Per-edge priority:
//     reset  -> PC = RESET_PC, IF/ID bubble
//     stall  -> PC and IF/ID hold (pc_src / imem_ready ignored)
//     redirect (pc_src != SEQ) -> PC = aligned target, IF/ID bubble
//                                 (wrong-path word squashed even if ready)
//     imem not ready -> PC holds, IF/ID bubble
//     otherwise      -> PC = PC+4, IF/ID loads the fetched word
//
//   Ports:
//     clk             rising-edge clock
//     reset           synchronous, active-high
//     stall           hazard-unit stall
//     pc_src          00 PC+4, 01 branch, 10 jump, 11 jr
//     branch_target   taken-branch address from ID
//     jump_target     j/jal address from ID
//     jr_target       register-indirect address from ID
//     imem            instruction-memory bus (master side)
//     pc              current PC register
//     if_id_instr     registered instruction to ID
//     if_id_pc_plus4  registered PC+4 of that instruction
//     if_id_valid     1 = real instruction, 0 = bubble
// ----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic [1:0]           pc_src,
   input  logic [31:0]          branch_target,
   input  logic [31:0]          jump_target,
   input  logic [31:0]          jr_target,
   fetch_stage_if.master        imem,
   output logic [31:0]          pc,
   output logic [31:0]          if_id_instr,
   output logic [31:0]          if_id_pc_plus4,
   output logic                 if_id_valid
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] target;
   logic        if_hold, if_bubble, if_load;

   // Next-PC mux; the SEQ leg only matters for the non-redirect path below.
   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      case (pc_src)
         mips_pkg::PC_SRC_BR: target = branch_target;
         mips_pkg::PC_SRC_J:  target = jump_target;
         mips_pkg::PC_SRC_JR: target = jr_target;
         default:             target = pc_plus4;
      endcase
   end

   always_comb begin
      pc_d      = pc_q;
      if_hold   = 1'b0;
      if_bubble = 1'b0;
      if_load   = 1'b0;
      if (stall) begin
         if_hold = 1'b1;
      end else if (pc_src != mips_pkg::PC_SRC_SEQ) begin
         pc_d      = mips_pkg::word_align(target);
         if_bubble = 1'b1;
      end else if (!imem.imem_ready) begin
         // Wait state: keep asking for the same address.
         if_bubble = 1'b1;
      end else begin
         pc_d    = pc_plus4;
         if_load = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= mips_pkg::word_align(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc             = pc_q;
   assign imem.imem_addr = pc_q;

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .reset      (reset),
      .hold_i     (if_hold),
      .bubble_i   (if_bubble),
      .load_i     (if_load),
      .instr_i    (imem.imem_rdata),
      .pc_plus4_i (pc_plus4),
      .instr_o    (if_id_instr),
      .pc_plus4_o (if_id_pc_plus4),
      .valid_o    (if_id_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Drives fetch_stage with directed scenarios followed by random traffic.
//   The driver computes each edge's expected pc / IF/ID contents from a
//   behavioural model and queues them; a monitor pops and compares one entry
//   per clock edge.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic [1:0]  pc_src = 2'b00;
   logic [31:0] branch_target = '0;
   logic [31:0] jump_target = '0;
   logic [31:0] jr_target = '0;
   logic        rdy = 1'b1;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_val = '0;

   logic [31:0] pc, if_id_instr, if_id_pc_plus4;
   logic        if_id_valid;

   always #5 clk = ~clk;

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
   endfunction

   fetch_stage_if bus ();

   assign bus.imem_ready = rdy;
   assign bus.imem_rdata = ovr_en ? ovr_val : mem_word(bus.imem_addr);

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .pc_src         (pc_src),
      .branch_target  (branch_target),
      .jump_target    (jump_target),
      .jr_target      (jr_target),
      .imem           (bus.master),
      .pc             (pc),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      string       tag;
   } exp_t;

   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;

   // Reference model state: what pc and IF/ID should hold after each edge.
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;

   task automatic chk(input string tag, input string field,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s got=%h exp=%h", tag, field, act, exp);
      end
   endtask

   task automatic m_bubble();
      m_instr = NOP;
      m_pc4   = 32'd0;
      m_valid = 1'b0;
   endtask

   // Apply one cycle of stimulus and queue the state expected after its edge.
   task automatic step(input logic rst, input logic st, input logic [1:0] src,
                       input logic [31:0] b, input logic [31:0] j,
                       input logic [31:0] r, input logic ry,
                       input logic use_ovr, input logic [31:0] ovr,
                       input string tag);
      logic [31:0] rd;
      logic [31:0] next_seq;
      exp_t        e;
      @(negedge clk);
      reset         = rst;
      stall         = st;
      pc_src        = src;
      branch_target = b;
      jump_target   = j;
      jr_target     = r;
      rdy           = ry;
      ovr_en        = use_ovr;
      ovr_val       = ovr;

      rd       = use_ovr ? ovr : mem_word(m_pc);
      next_seq = m_pc + 32'd4;
      if (rst) begin
         m_pc = RST_PC;
         m_bubble();
      end else if (st) begin
         // everything holds
      end else if (src != 2'b00) begin
         if (src == 2'b01)      m_pc = {b[31:2], 2'b00};
         else if (src == 2'b10) m_pc = {j[31:2], 2'b00};
         else                   m_pc = {r[31:2], 2'b00};
         m_bubble();
      end else if (!ry) begin
         m_bubble();
      end else begin
         m_instr = rd;
         m_pc4   = next_seq;
         m_valid = 1'b1;
         m_pc    = next_seq;
      end
      e.pc    = m_pc;
      e.instr = m_instr;
      e.pc4   = m_pc4;
      e.valid = m_valid;
      e.tag   = tag;
      exp_q.push_back(e);
   endtask

   task automatic seq(input string tag);
      step(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b0, '0, tag);
   endtask

   task automatic jump_to(input logic [31:0] a, input string tag);
      step(1'b0, 1'b0, 2'b10, '0, a, '0, 1'b1, 1'b0, '0, tag);
   endtask

   // Monitor: one expected entry per clock edge, sampled just after it.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk(e.tag, "pc", pc, e.pc);
         chk(e.tag, "imem_addr", bus.imem_addr, e.pc);
         chk(e.tag, "instr", if_id_instr, e.instr);
         chk(e.tag, "pc_plus4", if_id_pc_plus4, e.pc4);
         chk(e.tag, "valid", {31'd0, if_id_valid}, {31'd0, e.valid});
      end
   end

   initial begin
      // 1. reset then sequential fetch
      step(1'b1, 1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b1, 32'h2008_0005, "t1_reset");
      step(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b1, 32'h2008_0005, "t1_fetch");

      // 2. branch from 0x40 to unaligned 0x103 -> 0x100
      jump_to(32'h0000_0040, "t2_setup");
      step(1'b0, 1'b0, 2'b01, 32'h0000_0103, '0, '0, 1'b1, 1'b0, '0, "t2_branch");
      seq("t2_fetch100");

      // 3. stall wins over a pending jump for 3 cycles
      jump_to(32'h0000_001C, "t3_setup");
      seq("t3_to20");
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 2'b10, '0, 32'h0000_0400, '0, 1'b1, 1'b0, '0, "t3_stall");
      step(1'b0, 1'b0, 2'b10, '0, 32'h0000_0400, '0, 1'b1, 1'b0, '0, "t3_jump");

      // 4. two wait states at 0x10
      jump_to(32'h0000_0010, "t4_setup");
      for (int i = 0; i < 2; i++)
         step(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, "t4_wait");
      step(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b1, 1'b1, 32'hAC01_0000, "t4_ready");

      // 5. PC+4 wraps at the top of the address space
      jump_to(32'hFFFF_FFFC, "t5_setup");
      seq("t5_wrap");

      // 6. reset during stall with a pending jr
      jump_to(32'h0000_0080, "t6_setup");
      step(1'b0, 1'b1, 2'b11, '0, '0, 32'h0000_0200, 1'b1, 1'b0, '0, "t6_stall");
      step(1'b1, 1'b1, 2'b11, '0, '0, 32'h0000_0200, 1'b1, 1'b0, '0, "t6_reset");
      seq("t6_after");

      // redirect during a wait state: no stale data latched
      step(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, "t7_wait");
      step(1'b0, 1'b0, 2'b11, '0, '0, 32'h0000_0302, 1'b0, 1'b0, '0, "t7_jr");
      seq("t7_fetch");

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         logic       r_rst, r_st, r_ry;
         logic [1:0] r_src;
         r_rst = ($urandom_range(0, 63) == 0);
         r_st  = ($urandom_range(0, 3) == 0);
         r_src = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         r_ry  = ($urandom_range(0, 3) != 0);
         step(r_rst, r_st, r_src, $urandom, $urandom, $urandom, r_ry, 1'b0, '0, "rand");
      end

      @(negedge clk);
      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter and computes PC+4.
- Selects the next PC from a 2-bit pc_src code (same encoding as the 32-bit 4-way next-PC mux), drives the instruction-memory address, and registers the IF/ID pipeline latch.
- Handles hazard-unit stalls, control-transfer redirects with wrong-path squash, and instruction-memory wait states.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (low 2 bits must be 0).
NOP_INSTR, 32'h0000_0000, bubble instruction written into IF/ID (sll $0,$0,0).

Ports:
clk  in  1  rising-edge clock; the only clock.
reset  in  1  synchronous, active-high reset.
stall  in  1  hazard-unit stall; freeze PC and IF/ID.
pc_src  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr.
branch_target  in  32  taken-branch address from ID.
jump_target  in  32  j/jal address from ID.
jr_target  in  32  register-indirect address from ID (jr/jalr).
imem_addr  out  32  instruction-memory address; combinationally equals pc.
imem_rdata  in  32  instruction word for imem_addr.
imem_ready  in  1  imem_rdata is valid this cycle.
pc  out  32  current PC register.
if_id_instr  out  32  registered instruction to ID.
if_id_pc_plus4  out  32  registered PC+4 of that instruction.
if_id_valid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values (on the clk edge with reset=1): pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0. Reset has priority over every other input.
- Reset mid-stall or mid-wait discards all state. First fetch from RESET_PC occurs in the cycle after reset deasserts.
- pc_plus4 = pc + 32'd4, modulo 2^32: 0xFFFF_FFFC wraps to 0x0000_0000.
- Target alignment: bits [1:0] of every target are forced to 00 before loading into pc, so pc[1:0] is always 00.
- Per-edge update, first matching rule wins:
  1. reset: reset values as above.
  2. stall=1: pc, if_id_* hold. pc_src and imem_ready are ignored; the hazard unit holds pc_src stable until stall drops.
  3. pc_src!=00 (redirect): pc <= selected target; IF/ID <= bubble (NOP_INSTR, pc_plus4 field 0, valid 0). This squashes the wrong-path instruction even if imem_ready=1.
  4. imem_ready=0: pc holds; IF/ID <= bubble.
  5. Otherwise: pc <= pc_plus4; if_id_instr <= imem_rdata; if_id_pc_plus4 <= pc_plus4; if_id_valid <= 1.
- Latency:
  - Instruction at address A appears on if_id_* on the edge that samples A with imem_ready=1: one cycle after pc=A when memory is zero-wait.
  - Redirect penalty: exactly one bubble.
- Stall plus redirect in the same cycle: stall wins; the redirect is taken on the first non-stall cycle.
- Redirect while imem_ready=0: the redirect is taken; the pending fetch is abandoned and no stale data is latched.
- imem_addr is purely combinational from pc. No combinational path from any input to any output except via pc.

Decomposition:
- Shared package mips_pkg:
  - PC_SRC_SEQ=2'b00, PC_SRC_BR=2'b01, PC_SRC_J=2'b10, PC_SRC_JR=2'b11.
  - NOP_INSTR.
  - RESET_PC default.
  - Package constants are shared with the ID-stage control and the next-PC mux.
- One sub-module, if_id_reg: the IF/ID latch with load/bubble/hold controls and synchronous reset.
- PC register and next-PC selection stay in fetch_stage.

Test Plan:
1. Reset then run, imem_ready=1, pc_src=00, imem_rdata=0x2008_0005 -> after reset pc=0; next edge pc=4, if_id_instr=0x2008_0005, if_id_pc_plus4=4, valid=1.
2. pc=0x40, pc_src=01, branch_target=0x0000_0103, imem_ready=1 -> pc=0x100, if_id_instr=0, valid=0; following cycle fetches 0x100.
3. stall=1 for 3 cycles with pc=0x20 and pc_src=10, jump_target=0x400 -> pc and if_id_* unchanged for all 3 cycles; first edge after stall drops gives pc=0x400, valid=0.
4. imem_ready=0 for 2 cycles at pc=0x10, then 1 with rdata=0xAC01_0000 -> pc stays 0x10, two bubbles (valid=0), then if_id_instr=0xAC01_0000, pc_plus4=0x14, pc=0x14.
5. pc=0xFFFF_FFFC, pc_src=00, imem_ready=1 -> pc=0x0000_0000, if_id_pc_plus4=0x0000_0000, valid=1.
6. reset asserted during stall=1 with pc=0x80, pc_src=11, jr_target=0x200 -> pc=RESET_PC, valid=0 on that edge; jr is not taken.
